// File: rtl/led_uart_beacon.sv
// led_uart_beacon: board bring-up LED chaser plus periodic UART beacon.
//   The LED chaser steps a single lit position across NUM_LEDS outputs,
//   either bouncing between the ends or wrapping from the top back to 0.
//   The beacon sends MSG followed by CR LF through an external uart_tx,
//   using its start/data/ready handshake, one whole frame per period.
// Optional feature (compile-time macro STATUS_APPEND_EN):
//   when defined, ':' and the uppercase hex digit of the LED position
//   (latched when the frame starts) are inserted before CR LF.
module led_uart_beacon #(
  parameter int                   NUM_LEDS      = 6,
  parameter int                   STEP_CYCLES   = 2700000,
  parameter bit                   ACTIVE_LOW    = 1'b1,
  parameter int                   MSG_LEN       = 4,
  parameter logic [8*MSG_LEN-1:0] MSG           = "kuss",
  parameter int                   PERIOD_CYCLES = 27000000
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic                Mode_wrap,
  input  logic                Pause,
  output logic [NUM_LEDS-1:0] leds,
  output logic [7:0]          Tx_data,
  output logic                Tx_start,
  input  logic                Tx_ready
);

`ifdef STATUS_APPEND_EN
  localparam int FRAME_LEN = MSG_LEN + 4;
`else
  localparam int FRAME_LEN = MSG_LEN + 2;
`endif

  localparam int POS_W  = $clog2(NUM_LEDS);
  localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int PER_W  = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int IDX_W  = $clog2(FRAME_LEN);

  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(NUM_LEDS - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GUARD,
    S_WAIT
  } state_t;

  // LED chaser state
  logic [STEP_W-1:0]   step_cnt;
  logic [POS_W-1:0]    pos;
  logic                dir_down;
  logic [NUM_LEDS-1:0] onehot;

  // Beacon sequencer state
  state_t              state;
  logic [PER_W-1:0]    per_cnt;
  logic [IDX_W-1:0]    idx;

`ifdef STATUS_APPEND_EN
  // Status character captured once per frame so it cannot change mid-frame
  logic [7:0]          status_hex;

  function automatic logic [7:0] hex_ascii(input logic [3:0] d);
    if (d < 4'd10) hex_ascii = 8'h30 + {4'h0, d};
    else           hex_ascii = 8'h37 + {4'h0, d};
  endfunction
`endif

  // Character at position i of the frame: MSG (first char in the MSBs),
  // optional status pair, then CR LF.
  function automatic logic [7:0] frame_char(input logic [IDX_W-1:0] i_idx);
    int i;
    i = int'(i_idx);
    if (i < MSG_LEN)             frame_char = MSG[8*(MSG_LEN-1-i) +: 8];
`ifdef STATUS_APPEND_EN
    else if (i == MSG_LEN)       frame_char = 8'h3A;
    else if (i == MSG_LEN + 1)   frame_char = status_hex;
`endif
    else if (i == FRAME_LEN - 2) frame_char = 8'h0D;
    else                         frame_char = 8'h0A;
  endfunction

  // LED step timer and position update (bounce reflects without dwelling at the ends)
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      step_cnt <= '0;
      pos      <= '0;
      dir_down <= 1'b0;
    end else if (!Pause) begin
      if (step_cnt == STEP_LAST) begin
        step_cnt <= '0;
        if (Mode_wrap) begin
          // Wrap always ascends; a descending bounce resumes upward from here
          dir_down <= 1'b0;
          if (pos == POS_LAST) pos <= '0;
          else                 pos <= pos + 1'b1;
        end else if (!dir_down) begin
          if (pos == POS_LAST) begin
            dir_down <= 1'b1;
            pos      <= pos - 1'b1;
          end else begin
            pos      <= pos + 1'b1;
          end
        end else begin
          if (pos == '0) begin
            dir_down <= 1'b0;
            pos      <= pos + 1'b1;
          end else begin
            pos      <= pos - 1'b1;
          end
        end
      end else begin
        step_cnt <= step_cnt + 1'b1;
      end
    end
  end

  // LED drive: one-hot of the position, inverted for active-low boards
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      onehot[i] = (int'(pos) == i);
    end
    leds = ACTIVE_LOW ? ~onehot : onehot;
  end

  // Beacon sequencer: period pacing, start pulse and ready handshake with uart_tx
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state    <= S_IDLE;
      per_cnt  <= '0;
      idx      <= '0;
      Tx_start <= 1'b0;
      Tx_data  <= 8'h00;
    end else begin
      // Period counter measures from frame start and holds once elapsed
      if (per_cnt != PER_LAST) per_cnt <= per_cnt + 1'b1;
      Tx_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (per_cnt == PER_LAST && Tx_ready) begin
            state    <= S_SEND;
            per_cnt  <= '0;
            idx      <= '0;
            Tx_start <= 1'b1;
            Tx_data  <= frame_char('0);
          end
        end
        S_SEND: begin
          state <= S_GUARD;
        end
        // uart_tx may still report ready right after a start; skip that cycle
        S_GUARD: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (Tx_ready) begin
            if (idx != IDX_LAST) begin
              state    <= S_SEND;
              idx      <= idx + 1'b1;
              Tx_start <= 1'b1;
              Tx_data  <= frame_char(idx + 1'b1);
            end else begin
              state    <= S_IDLE;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef STATUS_APPEND_EN
  // Latch the position digit on the cycle the frame starts
  always_ff @(posedge Clock) begin
    if (state == S_IDLE && per_cnt == PER_LAST && Tx_ready) begin
      status_hex <= hex_ascii(4'(pos));
    end
  end
`endif

endmodule

// File: tb/tb_led_uart_beacon.sv
// tb_led_uart_beacon: directed-plus-random bench for led_uart_beacon with a
// behavioural LED/frame model and a simple busy-time model of uart_tx.
module tb_led_uart_beacon;

  localparam int NL = 4;
  localparam int SC = 3;
  localparam int ML = 2;
  localparam int PC = 40;
`ifdef STATUS_APPEND_EN
  localparam int FL = ML + 4;
`else
  localparam int FL = ML + 2;
`endif

  logic          Clock = 1'b0;
  logic          Reset_n;
  logic          Mode_wrap;
  logic          Pause;
  logic [NL-1:0] leds;
  logic [7:0]    Tx_data;
  logic          Tx_start;
  logic          Tx_ready;

  led_uart_beacon #(
    .NUM_LEDS      (NL),
    .STEP_CYCLES   (SC),
    .ACTIVE_LOW    (1'b1),
    .MSG_LEN       (ML),
    .MSG           ("ok"),
    .PERIOD_CYCLES (PC)
  ) dut (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .Mode_wrap (Mode_wrap),
    .Pause     (Pause),
    .leds      (leds),
    .Tx_data   (Tx_data),
    .Tx_start  (Tx_start),
    .Tx_ready  (Tx_ready)
  );

  always #5 Clock = ~Clock;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model state
  int         m_pos, m_dir, m_acnt;
  int         m_fstart, m_idle, m_last, m_sent;
  bit         m_inframe;
  bit         exp_start;
  logic [7:0] m_data;
`ifdef STATUS_APPEND_EN
  int         m_stat;
`endif

  // uart_tx busy model
  int busy     = 0;
  int busy_lo  = 0;
  int busy_hi  = 2;
  bit start_d1 = 1'b0;

  logic [7:0] seen[$];
  int         start_cyc[$];
  logic [7:0] msg_b [ML]        = '{8'h6F, 8'h6B};
  int         bounce_seq [9]    = '{0, 1, 2, 3, 2, 1, 0, 1, 2};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NL-1:0] enc(input int p);
    logic [NL-1:0] oh;
    oh    = '0;
    oh[p] = 1'b1;
    return ~oh;
  endfunction

  function automatic logic [7:0] exp_byte(input int k);
    if (k < ML) return msg_b[k];
`ifdef STATUS_APPEND_EN
    if (k == ML)     return 8'h3A;
    if (k == ML + 1) return (m_stat < 10) ? 8'(48 + m_stat) : 8'(55 + m_stat);
`endif
    if (k == FL - 2) return 8'h0D;
    return 8'h0A;
  endfunction

  // One LED step: wrap ascends modulo NL; bounce reflects off either end.
  task automatic advance(input bit wrap);
    if (wrap) begin
      m_dir = 1;
      m_pos = (m_pos + 1) % NL;
    end else begin
      if (m_pos + m_dir < 0 || m_pos + m_dir > NL - 1) m_dir = -m_dir;
      m_pos = m_pos + m_dir;
    end
  endtask

  // Advance one clock, update the model from the inputs that were stable
  // across the edge, compare all outputs, then update the uart_tx model.
  task automatic tick();
    bit rdy_last;
    int pos_before;
    @(posedge Clock);
    cyc++;
    @(negedge Clock);
    rdy_last   = Tx_ready;
    pos_before = m_pos;
    exp_start  = 1'b0;
    if (!Reset_n) begin
      m_pos     = 0;
      m_dir     = 1;
      m_acnt    = 0;
      m_inframe = 1'b0;
      m_sent    = 0;
      m_fstart  = cyc;
      m_idle    = cyc - 1;
      m_last    = cyc - 100;
      m_data    = 8'h00;
    end else begin
      if (!Pause) begin
        m_acnt++;
        if (m_acnt == SC) begin
          m_acnt = 0;
          advance(Mode_wrap);
        end
      end
      if (m_inframe) begin
        if (cyc >= m_last + 3 && rdy_last) begin
          if (m_sent < FL) exp_start = 1'b1;
          else begin
            m_inframe = 1'b0;
            m_idle    = cyc;
          end
        end
      end else if (cyc >= m_idle + 1 && cyc >= m_fstart + PC && rdy_last) begin
        m_inframe = 1'b1;
        m_fstart  = cyc;
        m_sent    = 0;
`ifdef STATUS_APPEND_EN
        m_stat    = pos_before;
`endif
        exp_start = 1'b1;
      end
      if (exp_start) begin
        m_data = exp_byte(m_sent);
        m_sent++;
        m_last = cyc;
      end
    end
    chk("leds", leds, enc(m_pos));
    chk("tx_start", Tx_start, exp_start);
    chk("tx_data", Tx_data, m_data);
    if (Tx_start) begin
      seen.push_back(Tx_data);
      start_cyc.push_back(cyc);
    end
    Tx_ready = (busy == 0);
    if (busy > 0) busy--;
    if (start_d1) busy = $urandom_range(busy_hi, busy_lo);
    start_d1 = Tx_start;
  endtask

  initial begin
    int n;
    int saved;
    int k;
    int rst_cyc;
    int base;
    int fa;

    Reset_n   = 1'b0;
    Mode_wrap = 1'b0;
    Pause     = 1'b0;
    Tx_ready  = 1'b1;

    // Reset held for two cycles
    tick();
    tick();
    chk("reset_leds", leds, 4'b1110);
    chk("reset_start", Tx_start, 1'b0);
    chk("reset_data", Tx_data, 8'h00);
    rst_cyc = cyc;
    Reset_n = 1'b1;

    // Bounce: one step every SC cycles, no repeated end value
    chk("bounce_0", leds, enc(bounce_seq[0]));
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (i % 3 == 0) chk($sformatf("bounce_%0d", i / 3), leds, enc(bounce_seq[i / 3]));
    end

    // Wrap: climb to the top, then 3 -> 0
    Mode_wrap = 1'b1;
    n = 0;
    while (m_pos != NL - 1 && n < 20) begin
      tick();
      n++;
    end
    chk("wrap_top", leds, enc(NL - 1));
    tick(); tick(); tick();
    chk("wrap_to_0", leds, enc(0));

    // Pause freezes the position and the step phase
    tick();
    saved = m_pos;
    Pause = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("pause_hold", leds, enc(saved));
    Pause = 1'b0;
    k = SC - m_acnt;
    for (int i = 0; i < k - 1; i++) tick();
    chk("resume_phase_hold", leds, enc(saved));
    tick();
    chk("resume_phase_step", leds, enc((saved + 1) % NL));

    // Random LED inputs with a fast uart_tx: frames every PC cycles
    n = 0;
    while (seen.size() < 3 * FL && n < 400) begin
      if ($urandom_range(0, 15) == 0) Mode_wrap = 1'($urandom_range(0, 1));
      Pause = ($urandom_range(0, 7) == 0);
      tick();
      n++;
    end
    chk("frames_timeout", (seen.size() >= 3 * FL), 1'b1);
    if (seen.size() >= 2 * FL + 1) begin
      chk("f0_b0", seen[0], 8'h6F);
      chk("f0_b1", seen[1], 8'h6B);
`ifdef STATUS_APPEND_EN
      chk("f0_colon", seen[ML], 8'h3A);
`endif
      chk("f0_cr", seen[FL - 2], 8'h0D);
      chk("f0_lf", seen[FL - 1], 8'h0A);
      chk("f1_b0", seen[FL], 8'h6F);
      chk("first_frame_delay", start_cyc[0] - rst_cyc, PC);
      chk("frame_period", start_cyc[FL] - start_cyc[0], PC);
      chk("byte_spacing_min", (start_cyc[1] - start_cyc[0] >= 3), 1'b1);
    end

    // Overrun: slow uart_tx, next frame follows the previous one directly
    busy_lo = 20;
    busy_hi = 30;
    base = seen.size();
    fa = ((base + FL - 1) / FL) * FL;
    n = 0;
    while (seen.size() < fa + FL + 1 && n < 1500) begin
      Pause = ($urandom_range(0, 3) == 0);
      tick();
      n++;
    end
    chk("overrun_timeout", (seen.size() >= fa + FL + 1), 1'b1);
    if (seen.size() >= fa + FL + 1) begin
      chk("overrun_gap_gt_period", (start_cyc[fa + FL] - start_cyc[fa] > PC), 1'b1);
      chk("overrun_next_b0", seen[fa + FL], 8'h6F);
      chk("overrun_last_lf", seen[fa + FL - 1], 8'h0A);
    end

    // Mid-frame reset during the second byte
    n = 0;
    while (!(exp_start && m_sent == 2) && n < 500) begin
      tick();
      n++;
    end
    chk("second_byte_timeout", (exp_start && m_sent == 2), 1'b1);
    Reset_n = 1'b0;
    tick();
    chk("midreset_start", Tx_start, 1'b0);
    tick();
    chk("midreset_data", Tx_data, 8'h00);
    rst_cyc = cyc;
    Reset_n = 1'b1;
    busy_lo = 0;
    busy_hi = 2;
    base = seen.size();
    n = 0;
    while (seen.size() == base && n < 100) begin
      tick();
      n++;
    end
    chk("restart_timeout", (seen.size() > base), 1'b1);
    if (seen.size() > base) begin
      chk("restart_delay", start_cyc[base] - rst_cyc, PC);
      chk("restart_b0", seen[base], 8'h6F);
    end
    for (int i = 0; i < 20; i++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
